cell_color_pipe: RTL and testbench
==================================

CELL_COLOR_PIPE -- requirements
Module: cell_color_pipe

Interface
REQ-001 SHALL have parameter STATE_W, default 10, width of the cell-state word.
REQ-002 SHALL have parameter COLOR_W, default 8, bits per colour channel; legal range 4..8.
REQ-003 SHALL have parameter BLINK_DIV, default 30, frame_tick pulses per blink half-period; legal range 1 or more.
REQ-004 SHALL have parameters FLAG_BIT=4, EARTH_BIT=5, UNLOCK_BIT=6, LOCK_BIT=7, each the bit index of that state flag.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  system/pixel clock; all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 pix_valid  in  1  state/inpos valid this cycle (active video).
REQ-009 state  in  STATE_W  cell-state word.
REQ-010 inpos  in  1  cursor is on this cell.
REQ-011 frame_tick  in  1  one-cycle pulse per video frame.
REQ-012 pal_we  in  1  palette write strobe.
REQ-013 pal_addr  in  3  palette entry index.
REQ-014 pal_data  in  3*COLOR_W  palette write data, {R,G,B}.
REQ-015 rgb  out  3*COLOR_W  pixel colour, {R,G,B}.
REQ-016 rgb_valid  out  1  rgb corresponds to a valid input.
REQ-017 blink_phase  out  1  current blink phase.

Function
REQ-018 Stage 1 SHALL register a 3-bit class, inpos and pix_valid. Class priority, highest first: flag=0, earth=1, unlocked=2, locked=3, none=4.
REQ-019 Stage 2 SHALL register rgb and rgb_valid from stage 1. Input-to-output latency is exactly 2 cycles, with a throughput of 1 pixel per cycle.
REQ-020 Palette SHALL hold 8 entries. Entry roles: 0 flag, 1 earth, 2 unlocked, 3 locked, 4 none, 5 cursor, 6 flag-blink, 7 spare.
REQ-021 Colour select in stage 2 SHALL be, first match wins:
- inpos=1: entry 5.
- class=0 and blink_phase=1: entry 6.
- otherwise: entry[class].
REQ-022 When stage-1 pix_valid=0, the module SHALL output rgb=0 and rgb_valid=0 (blanking).
REQ-023 When pal_we=1, entry pal_addr SHALL be written at the clock edge. A stage-2 read of the same entry in the same cycle returns the old value; the new value applies from the next cycle.
REQ-024 The blink counter SHALL count frame_tick pulses from 0 to BLINK_DIV-1, then wrap to 0. On the wrap, blink_phase toggles in the same cycle.
REQ-025 frame_tick SHALL be honoured regardless of pix_valid. A frame_tick in the same cycle as rst is ignored.
REQ-026 A blink_phase change SHALL affect rgb starting from pixels in stage 2 on the next cycle; pixels already in the pipeline are not re-coloured.

Reset
REQ-027 With rst=1, the module SHALL clear the following at the edge: rgb=0, rgb_valid=0, blink_phase=0, blink counter=0, both pipeline valid bits=0.
REQ-028 Reset SHALL reload the palette defaults, 8-bit RGB, truncated to the COLOR_W MSBs per channel: 0=FF0000, 1=B8860B, 2=0000FF, 3=C000C0, 4=0000FF, 5=FFFF00, 6=000000, 7=000000.
REQ-029 Reset asserted mid-stream SHALL drop in-flight pixels. rgb_valid stays 0 until 2 cycles after the first valid input following reset.
REQ-030 A pal_we asserted during reset SHALL be ignored.

Configuration
REQ-031 Macro CELL_COLOR_BLINK_EN SHALL control the blink feature. When defined, the blink counter and blink_phase logic exist and behave as specified above.
REQ-032 When CELL_COLOR_BLINK_EN is undefined:
- the blink counter is absent;
- blink_phase is tied to 0;
- frame_tick is ignored;
- flag cells always use entry 0;
- entry 6 stays writable but is never selected.

Verification
REQ-033 Reset, then state=0x010, inpos=0, pix_valid=1 for 1 cycle -> 2 cycles later rgb=FF0000, rgb_valid=1, for 1 cycle.
REQ-034 state=0x0F0 (all four flags set), then 0x0E0, then 0x0C0, then 0x080, on consecutive cycles -> rgb sequence FF0000, B8860B, 0000FF, C000C0, each 2 cycles after its input.
REQ-035 BLINK_DIV=2, flag cell held valid, 2 frame_tick pulses -> blink_phase goes 1 and rgb becomes 000000. After 2 further pulses -> rgb returns to FF0000. Repeat with the macro undefined -> rgb stays FF0000.
REQ-036 pal_we=1, pal_addr=2, pal_data=00FF00 while an unlocked pixel is in stage 2 -> that pixel gives 0000FF and the next one gives 00FF00.
REQ-037 Stream of valid pixels with inpos=1 on a flag cell in blink phase 1 -> rgb=FFFF00; drop pix_valid for 1 cycle -> rgb=0 and rgb_valid=0 for exactly 1 cycle.
REQ-038 rst pulsed for 1 cycle mid-stream after palette writes -> in-flight pixels are dropped, blink_phase=0, and entry 2 reads back 0000FF.

Source files
------------

// File: rtl/cell_color_pipe.sv
// cell_color_pipe: maps a cell-state word to a pixel colour through a writable 8-entry palette.
// Latency 2 cycles (class register, then colour register); 1 pixel/cycle; no backpressure (free-running video).
// Optional blink feature: define CELL_COLOR_BLINK_EN to enable the frame_tick driven blink counter.
// Ports: clk/rst (sync, active-high); pix_valid/state/inpos pixel input; frame_tick frame pulse;
//        pal_we/pal_addr/pal_data palette write port; rgb/rgb_valid pixel output; blink_phase current phase.
module cell_color_pipe #(
  parameter int STATE_W    = 10,
  parameter int COLOR_W    = 8,
  parameter int BLINK_DIV  = 30,
  parameter int FLAG_BIT   = 4,
  parameter int EARTH_BIT  = 5,
  parameter int UNLOCK_BIT = 6,
  parameter int LOCK_BIT   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic [STATE_W-1:0]   state,
  input  logic                 inpos,
  input  logic                 frame_tick,
  input  logic                 pal_we,
  input  logic [2:0]           pal_addr,
  input  logic [3*COLOR_W-1:0] pal_data,
  output logic [3*COLOR_W-1:0] rgb,
  output logic                 rgb_valid,
  output logic                 blink_phase
);

  localparam int PW = 3*COLOR_W;

  // Reset palette: 8-bit-per-channel defaults, keeping the COLOR_W MSBs of each channel.
  function automatic logic [PW-1:0] pal_default(input logic [2:0] idx);
    logic [23:0] c;
    c = 24'h000000;
    case (idx)
      3'd0:    c = 24'hFF0000;
      3'd1:    c = 24'hB8860B;
      3'd2:    c = 24'h0000FF;
      3'd3:    c = 24'hC000C0;
      3'd4:    c = 24'h0000FF;
      3'd5:    c = 24'hFFFF00;
      default: c = 24'h000000;
    endcase
    return {c[23 -: COLOR_W], c[15 -: COLOR_W], c[7 -: COLOR_W]};
  endfunction

  logic [PW-1:0] pal [8];
  logic [2:0]    cls_d;
  logic [2:0]    s1_cls;
  logic          s1_inpos;
  logic          s1_vld;
  logic [2:0]    sel;

  // Only the four flag bits matter; the rest of the state word is intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{state, frame_tick};

  // Class priority: flag > earth > unlocked > locked > none.
  always_comb begin
    cls_d = 3'd4;
    if (state[FLAG_BIT])        cls_d = 3'd0;
    else if (state[EARTH_BIT])  cls_d = 3'd1;
    else if (state[UNLOCK_BIT]) cls_d = 3'd2;
    else if (state[LOCK_BIT])   cls_d = 3'd3;
  end

  // Stage 1: only the valid bit needs reset; class/inpos are qualified by it.
  always_ff @(posedge clk) begin
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= pix_valid;
    s1_cls   <= cls_d;
    s1_inpos <= inpos;
  end

  // Cursor overrides everything; blink only recolours flag cells.
  always_comb begin
    sel = s1_cls;
    if (s1_inpos)                             sel = 3'd5;
    else if (s1_cls == 3'd0 && blink_phase)   sel = 3'd6;
  end

  // Stage 2 reads the palette before this edge's write lands, so a same-cycle
  // write to the selected entry yields the old colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s1_vld;
      rgb       <= s1_vld ? pal[sel] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pal[i] <= pal_default(3'(i));
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

`ifdef CELL_COLOR_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [CNT_W-1:0] blink_cnt;

  // Phase toggles on the same edge that wraps the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_W'(BLINK_DIV-1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign blink_phase = 1'b0;
`endif

endmodule

// File: tb/tb_cell_color_pipe.sv
// tb_cell_color_pipe: randomized + directed scoreboard bench for cell_color_pipe.
// Expected colours come from a palette/blink reference model; a monitor compares on every output cycle.
// Works with or without CELL_COLOR_BLINK_EN defined.
module tb_cell_color_pipe;
  localparam int STATE_W   = 10;
  localparam int COLOR_W   = 8;
  localparam int BLINK_DIV = 2;
`ifdef CELL_COLOR_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               pix_valid;
  logic [STATE_W-1:0] state;
  logic               inpos;
  logic               frame_tick;
  logic               pal_we;
  logic [2:0]         pal_addr;
  logic [23:0]        pal_data;
  logic [23:0]        rgb;
  logic               rgb_valid;
  logic               blink_phase;

  always #5 clk = ~clk;

  cell_color_pipe #(
    .STATE_W(STATE_W), .COLOR_W(COLOR_W), .BLINK_DIV(BLINK_DIV),
    .FLAG_BIT(4), .EARTH_BIT(5), .UNLOCK_BIT(6), .LOCK_BIT(7)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .state(state), .inpos(inpos),
    .frame_tick(frame_tick), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .rgb(rgb), .rgb_valid(rgb_valid), .blink_phase(blink_phase)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] col;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: palette contents, frame count within half-period, phase.
  logic [23:0] m_pal [8];
  int          m_cnt;
  bit          m_phase;
  bit          pend_vld;
  int          pend_cls;
  bit          pend_inpos;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_pal[0] = 24'hFF0000; m_pal[1] = 24'hB8860B; m_pal[2] = 24'h0000FF; m_pal[3] = 24'hC000C0;
    m_pal[4] = 24'h0000FF; m_pal[5] = 24'hFFFF00; m_pal[6] = 24'h000000; m_pal[7] = 24'h000000;
    m_cnt    = 0;
    m_phase  = 1'b0;
    pend_vld = 1'b0;
  endtask

  function automatic int class_of(input logic [STATE_W-1:0] s);
    if (s[4]) return 0;
    if (s[5]) return 1;
    if (s[6]) return 2;
    if (s[7]) return 3;
    return 4;
  endfunction

  // One clock of stimulus. The pixel issued on the previous call is coloured at the
  // coming edge, using the palette/phase as they stand after all earlier edges.
  task automatic step(input bit r, input bit v, input logic [STATE_W-1:0] s, input bit ip,
                      input bit ft, input bit we, input logic [2:0] a, input logic [23:0] d);
    logic [23:0] col;
    @(negedge clk);
    check("blink_phase", 32'(blink_phase), 32'(m_phase));
    if (pend_vld && !r) begin
      if (pend_inpos)                      col = m_pal[5];
      else if (pend_cls == 0 && m_phase)   col = m_pal[6];
      else                                 col = m_pal[pend_cls];
      exp_q.push_back('{col: col, due: cyc + 1});
    end
    rst = r; pix_valid = v; state = s; inpos = ip; frame_tick = ft;
    pal_we = we; pal_addr = a; pal_data = d;
    pend_vld   = v && !r;
    pend_cls   = class_of(s);
    pend_inpos = ip;
    if (r) begin
      model_reset();
    end else begin
      if (we) m_pal[a] = d;
      if (ft && BLINK_EN) begin
        m_cnt++;
        if (m_cnt == BLINK_DIV) begin
          m_cnt   = 0;
          m_phase = !m_phase;
        end
      end
    end
  endtask

  task automatic px(input bit v, input logic [STATE_W-1:0] s, input bit ip, input bit ft);
    step(1'b0, v, s, ip, ft, 1'b0, 3'd0, 24'h0);
  endtask

  // Monitor: every output cycle either matches the scoreboard head or is blank.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (rgb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pixel at cycle %0d: got rgb %h, expected no output", cyc, rgb);
        end else begin
          e = exp_q.pop_front();
          check("rgb", 32'(rgb), 32'(e.col));
          check("latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        check("rgb_valid", 32'(rgb_valid), 32'd0);
        check("blank_rgb", 32'(rgb), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          n_cmp++; n_bad++;
          $display("FAIL missing_pixel at cycle %0d: got none, expected rgb %h", cyc, e.col);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b1; state = 10'h010; inpos = 1'b0; frame_tick = 1'b1;
    pal_we = 1'b1; pal_addr = 3'd0; pal_data = 24'h123456;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    check("reset_rgb", 32'(rgb), 32'd0);
    check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
    check("reset_blink_phase", 32'(blink_phase), 32'd0);
    // Leave reset with no valid input so the first real pixel starts cleanly.
    rst = 1'b0; pix_valid = 1'b0; frame_tick = 1'b0; pal_we = 1'b0;
    mon_en = 1'b1;

    // Single flag pixel, then the four-flag priority sequence.
    px(1, 10'h010, 0, 0);
    px(0, 10'h000, 0, 0);
    px(0, 10'h000, 0, 0);
    px(1, 10'h0F0, 0, 0);
    px(1, 10'h0E0, 0, 0);
    px(1, 10'h0C0, 0, 0);
    px(1, 10'h080, 0, 0);
    px(1, 10'h300, 0, 0);
    px(0, 10'h000, 0, 0);

    // Blink: flag cell held valid across frame ticks.
    for (int i = 0; i < 24; i++) px(1, 10'h010, 0, (i % 6) == 2);

    // Palette write while an unlocked pixel sits in stage 1 -> old then new colour.
    px(1, 10'h040, 0, 0);
    step(0, 1, 10'h040, 0, 0, 1, 3'd2, 24'h00FF00);
    px(1, 10'h040, 0, 0);
    px(1, 10'h040, 0, 0);

    // Cursor on a flag cell, with a one-cycle gap in the stream.
    px(1, 10'h010, 0, 1);
    for (int i = 0; i < 6; i++) px(1, 10'h010, 1, 0);
    px(0, 10'h010, 1, 0);
    for (int i = 0; i < 4; i++) px(1, 10'h010, 1, 0);

    // Mid-stream reset after palette writes, with a write and tick during reset.
    step(0, 1, 10'h040, 0, 0, 1, 3'd6, 24'hABCDEF);
    px(1, 10'h040, 0, 1);
    px(1, 10'h010, 0, 0);
    step(1, 1, 10'h040, 0, 1, 1, 3'd2, 24'h777777);
    for (int i = 0; i < 5; i++) px(1, 10'h040, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(9) < 8), 10'($urandom),
           ($urandom_range(4) == 0), ($urandom_range(4) == 0), ($urandom_range(9) == 0),
           3'($urandom), 24'($urandom));
    end

    for (int i = 0; i < 4; i++) px(0, 10'h000, 0, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the clock or stimulus ever stalls.
  initial begin
    #1000000;
    $display("FAIL timeout at cycle %0d: got no completion, expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
